// File: rtl/gpio_in_conditioner_if.sv
// Bus bundle between the switch conditioner and the core side.
// The interrupt signals exist only when GPIO_IN_IRQ_EN is defined.
interface gpio_in_conditioner_if #(
    parameter int WIDTH = 9
);
    logic [WIDTH-1:0] gpio_raw;
    logic [WIDTH-1:0] gpio_o;
    logic [WIDTH-1:0] rise_o;
    logic [WIDTH-1:0] fall_o;
    logic [WIDTH-1:0] clr_i;
    logic             changed_o;
`ifdef GPIO_IN_IRQ_EN
    logic [WIDTH-1:0] irq_mask_i;
    logic             irq_o;

    modport master (
        output gpio_raw, clr_i, irq_mask_i,
        input  gpio_o, rise_o, fall_o, changed_o, irq_o
    );
    modport slave (
        input  gpio_raw, clr_i, irq_mask_i,
        output gpio_o, rise_o, fall_o, changed_o, irq_o
    );
`else
    modport master (
        output gpio_raw, clr_i,
        input  gpio_o, rise_o, fall_o, changed_o
    );
    modport slave (
        input  gpio_raw, clr_i,
        output gpio_o, rise_o, fall_o, changed_o
    );
`endif
endinterface

// File: rtl/gpio_in_conditioner.sv
// Switch conditioner: 2-flop synchroniser, per-bit debounce, sticky rise/fall flags (W1C).
// Define GPIO_IN_IRQ_EN to add the masked interrupt output.
module gpio_in_conditioner #(
    parameter int WIDTH           = 9,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                 clk,
    input  logic                 rst,
    gpio_in_conditioner_if.slave bus
);
    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] level_nxt;
    logic [CNT_W-1:0] cnt     [WIDTH];
    logic [CNT_W-1:0] cnt_nxt [WIDTH];
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] fall_q;
    logic [WIDTH-1:0] rise_nxt;
    logic [WIDTH-1:0] fall_nxt;
    logic [WIDTH-1:0] rise_set;
    logic [WIDTH-1:0] fall_set;
    logic             changed_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= bus.gpio_raw;
            sync2 <= sync1;
        end
    end

    // Counter only runs while the synchronised input disagrees with the accepted level.
    always_comb begin
        level_nxt = level;
        cnt_nxt   = '{default: '0};
        for (int i = 0; i < WIDTH; i++) begin
            if (sync2[i] != level[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    level_nxt[i] = sync2[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // A set on the same edge as a clear wins so no event is lost.
    always_comb begin
        rise_set = level_nxt & ~level;
        fall_set = ~level_nxt & level;
        rise_nxt = (rise_q & ~bus.clr_i) | rise_set;
        fall_nxt = (fall_q & ~bus.clr_i) | fall_set;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level     <= '0;
            cnt       <= '{default: '0};
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            level     <= level_nxt;
            cnt       <= cnt_nxt;
            rise_q    <= rise_nxt;
            fall_q    <= fall_nxt;
            changed_q <= |(rise_q | fall_q);
        end
    end

    assign bus.gpio_o    = level;
    assign bus.rise_o    = rise_q;
    assign bus.fall_o    = fall_q;
    assign bus.changed_o = changed_q;

`ifdef GPIO_IN_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |((rise_q | fall_q) & bus.irq_mask_i);
        end
    end

    assign bus.irq_o = irq_q;
`endif
endmodule

// File: tb/tb_gpio_in_conditioner.sv
// Bench for gpio_in_conditioner: directed scenarios plus random switch activity against a window model.
// Interrupt checks are active when GPIO_IN_IRQ_EN is defined.
module tb_gpio_in_conditioner;
    localparam int W = 9;
    localparam int D = 4;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    gpio_in_conditioner_if #(.WIDTH(W)) bus ();

    gpio_in_conditioner #(
        .WIDTH(W),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk(clk),
        .rst(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a level is accepted once the last D synchronised samples
    // (all taken since reset) disagree with the current level.
    logic [W-1:0] hist [$];
    int           edges;
    logic [W-1:0] m_gpio;
    logic [W-1:0] m_rise;
    logic [W-1:0] m_fall;
    logic         m_changed;
    logic         m_irq;

    function automatic void model_reset();
        hist.delete();
        edges     = 0;
        m_gpio    = '0;
        m_rise    = '0;
        m_fall    = '0;
        m_changed = 1'b0;
        m_irq     = 1'b0;
    endfunction

    function automatic void model_edge();
        logic [W-1:0] ng;
        logic [W-1:0] r_set;
        logic [W-1:0] f_set;
        logic         all_diff;
        logic         s;
        hist.push_front(bus.gpio_raw);
        if (hist.size() > D + 2) void'(hist.pop_back());
        if (edges < D) edges++;
        ng = m_gpio;
        for (int i = 0; i < W; i++) begin
            all_diff = (edges >= D);
            for (int j = 0; j < D; j++) begin
                s = (2 + j < hist.size()) ? hist[2 + j][i] : 1'b0;
                if (s == m_gpio[i]) all_diff = 1'b0;
            end
            if (all_diff) ng[i] = ~m_gpio[i];
        end
        r_set     = ng & ~m_gpio;
        f_set     = ~ng & m_gpio;
        m_changed = |(m_rise | m_fall);
`ifdef GPIO_IN_IRQ_EN
        m_irq     = |((m_rise | m_fall) & bus.irq_mask_i);
`endif
        m_rise    = (m_rise & ~bus.clr_i) | r_set;
        m_fall    = (m_fall & ~bus.clr_i) | f_set;
        m_gpio    = ng;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_gpio"}, 32'(bus.gpio_o), 32'(m_gpio));
        chk({tag, "_rise"}, 32'(bus.rise_o), 32'(m_rise));
        chk({tag, "_fall"}, 32'(bus.fall_o), 32'(m_fall));
        chk({tag, "_changed"}, 32'(bus.changed_o), 32'(m_changed));
`ifdef GPIO_IN_IRQ_EN
        chk({tag, "_irq"}, 32'(bus.irq_o), 32'(m_irq));
`endif
    endtask

    // One clock: model advances on the rising edge, DUT is compared on the falling edge.
    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_model(tag);
    endtask

    initial begin
        int b;
        vectors      = 0;
        miscompares  = 0;
        rst_n        = 1'b0;
        bus.gpio_raw = '0;
        bus.clr_i    = '0;
`ifdef GPIO_IN_IRQ_EN
        bus.irq_mask_i = 9'h004;
`endif
        model_reset();
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        // Quiet inputs after reset release
        for (int n = 0; n < 20; n++) begin
            step("t1");
            chk("t1_gpio_zero", 32'(bus.gpio_o), 32'h0);
            chk("t1_flags_zero", 32'(bus.rise_o | bus.fall_o), 32'h0);
        end

        // Bit 0 held high: accepted at edge D+2, changed one edge later
        bus.gpio_raw[0] = 1'b1;
        repeat (5) step("t2");
        chk("t2_gpio_e5", 32'(bus.gpio_o), 32'h000);
        step("t2");
        chk("t2_gpio_e6", 32'(bus.gpio_o), 32'h001);
        chk("t2_rise_e6", 32'(bus.rise_o), 32'h001);
        chk("t2_changed_e6", 32'(bus.changed_o), 32'h0);
        step("t2");
        chk("t2_changed_e7", 32'(bus.changed_o), 32'h1);

        // Three-cycle glitch on bit 3 must be rejected
        bus.gpio_raw[3] = 1'b1;
        repeat (3) step("t3");
        bus.gpio_raw[3] = 1'b0;
        for (int n = 0; n < 20; n++) begin
            step("t3");
            chk("t3_gpio3", 32'(bus.gpio_o[3]), 32'h0);
            chk("t3_rise3", 32'(bus.rise_o[3]), 32'h0);
        end

        // Fall on bit 0 coinciding with a clear: set wins, rise cleared
        bus.gpio_raw[0] = 1'b0;
        repeat (5) step("t4");
        bus.clr_i = 9'h001;
        step("t4");
        bus.clr_i = '0;
        chk("t4_fall0", 32'(bus.fall_o[0]), 32'h1);
        chk("t4_rise0", 32'(bus.rise_o[0]), 32'h0);
        step("t4");

`ifdef GPIO_IN_IRQ_EN
        // Only masked-in bits raise the interrupt
        bus.clr_i = 9'h1FF;
        step("t6");
        bus.clr_i = '0;
        repeat (2) step("t6");
        bus.gpio_raw[1] = 1'b1;
        repeat (8) step("t6");
        chk("t6_irq_bit1", 32'(bus.irq_o), 32'h0);
        bus.gpio_raw[2] = 1'b1;
        repeat (8) step("t6");
        chk("t6_irq_bit2", 32'(bus.irq_o), 32'h1);
        bus.clr_i = 9'h004;
        step("t6");
        bus.clr_i = '0;
        chk("t6_irq_clr_e1", 32'(bus.irq_o), 32'h1);
        step("t6");
        chk("t6_irq_clr_e2", 32'(bus.irq_o), 32'h0);
        bus.gpio_raw = '0;
        repeat (8) step("t6");
`endif

        // Reset mid-count clears everything at once
        bus.gpio_raw = 9'h1FF;
        repeat (4) step("t5");
        bus.gpio_raw = '0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("t5_gpio_async", 32'(bus.gpio_o), 32'h0);
        chk("t5_rise_async", 32'(bus.rise_o), 32'h0);
        chk("t5_fall_async", 32'(bus.fall_o), 32'h0);
        chk("t5_changed_async", 32'(bus.changed_o), 32'h0);
`ifdef GPIO_IN_IRQ_EN
        chk("t5_irq_async", 32'(bus.irq_o), 32'h0);
`endif
        @(negedge clk);
        #2 rst_n = 1'b1;
        for (int n = 0; n < 20; n++) begin
            step("t5");
            chk("t5_no_event", 32'(bus.rise_o | bus.fall_o | bus.gpio_o), 32'h0);
        end

        // Random switch activity with occasional clears
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                b = $urandom_range(0, 3);
                bus.gpio_raw[b] = ~bus.gpio_raw[b];
            end
            if ($urandom_range(0, 19) == 0) begin
                b = $urandom_range(4, W - 1);
                bus.gpio_raw[b] = ~bus.gpio_raw[b];
            end
            bus.clr_i = ($urandom_range(0, 7) == 0) ? W'($urandom) : '0;
`ifdef GPIO_IN_IRQ_EN
            if ($urandom_range(0, 49) == 0) bus.irq_mask_i = W'($urandom);
`endif
            step("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
